// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EXE/MEM register, 2^DMEM_AW x 16 data memory, MEM/WB register; EXE -> WB in 2 edges, 1 instr/cycle.
// stall holds EXE/MEM and injects a WB bubble; define EXE_MEM_FWD_EN to drive the fwd_* outputs (else tied 0).
module mem_wb_stage #(
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluout,
  input  logic [15:0] rdata2_in,
  input  logic [3:0]  waddr_in,
  input  logic        regwrite_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        stall,
  output logic [15:0] aluout_out_EXE_MEM,
  output logic [3:0]  waddr_out_EXE_MEM,
  output logic [15:0] wdata_WB,
  output logic [3:0]  waddr_WB,
  output logic        wen_WB,
  output logic        fwd_en_MEM,
  output logic [3:0]  fwd_waddr_MEM,
  output logic [15:0] fwd_data_MEM,
  output logic        fwd_en_WB,
  output logic [3:0]  fwd_waddr_WB,
  output logic [15:0] fwd_data_WB
);

  logic [15:0]        rdata2_EXE_MEM;
  logic               regwrite_EXE_MEM;
  logic               memread_EXE_MEM;
  logic               memwrite_EXE_MEM;
  logic [15:0]        mem [0:(1<<DMEM_AW)-1];
  logic [DMEM_AW-1:0] dmem_addr;
  logic [15:0]        dmem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluout_out_EXE_MEM <= '0;
      rdata2_EXE_MEM     <= '0;
      waddr_out_EXE_MEM  <= '0;
      regwrite_EXE_MEM   <= 1'b0;
      memread_EXE_MEM    <= 1'b0;
      memwrite_EXE_MEM   <= 1'b0;
    end else if (!stall) begin
      aluout_out_EXE_MEM <= aluout;
      rdata2_EXE_MEM     <= rdata2_in;
      waddr_out_EXE_MEM  <= waddr_in;
      regwrite_EXE_MEM   <= regwrite_in;
      memread_EXE_MEM    <= memread_in;
      memwrite_EXE_MEM   <= memwrite_in;
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo the memory depth.
  assign dmem_addr  = aluout_out_EXE_MEM[DMEM_AW-1:0];
  assign dmem_rdata = mem[dmem_addr];

  // Gating on stall keeps a held store from committing more than once.
  always_ff @(posedge clk) begin
    if (memwrite_EXE_MEM && !stall) begin
      mem[dmem_addr] <= rdata2_EXE_MEM;
    end
  end

  // Stall turns the WB slot into a bubble; data/address keep their old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_WB <= '0;
      waddr_WB <= '0;
      wen_WB   <= 1'b0;
    end else if (stall) begin
      wen_WB   <= 1'b0;
    end else begin
      wdata_WB <= memread_EXE_MEM ? dmem_rdata : aluout_out_EXE_MEM;
      waddr_WB <= waddr_out_EXE_MEM;
      wen_WB   <= regwrite_EXE_MEM && (waddr_out_EXE_MEM != 4'd0);
    end
  end

`ifdef EXE_MEM_FWD_EN
  // Loads are not forwardable from EXE/MEM: their data only exists at WB.
  assign fwd_en_MEM    = regwrite_EXE_MEM && !memread_EXE_MEM && (waddr_out_EXE_MEM != 4'd0);
  assign fwd_waddr_MEM = waddr_out_EXE_MEM;
  assign fwd_data_MEM  = aluout_out_EXE_MEM;
  assign fwd_en_WB     = wen_WB;
  assign fwd_waddr_WB  = waddr_WB;
  assign fwd_data_WB   = wdata_WB;
`else
  assign fwd_en_MEM    = 1'b0;
  assign fwd_waddr_MEM = 4'd0;
  assign fwd_data_MEM  = 16'd0;
  assign fwd_en_WB     = 1'b0;
  assign fwd_waddr_WB  = 4'd0;
  assign fwd_data_WB   = 16'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of expected WB results, one task per scenario.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluout, rdata2_in;
  logic [3:0]  waddr_in;
  logic        regwrite_in, memread_in, memwrite_in, stall;
  logic [15:0] aluout_out_EXE_MEM, wdata_WB, fwd_data_MEM, fwd_data_WB;
  logic [3:0]  waddr_out_EXE_MEM, waddr_WB, fwd_waddr_MEM, fwd_waddr_WB;
  logic        wen_WB, fwd_en_MEM, fwd_en_WB;

  mem_wb_stage #(.DMEM_AW(8)) dut (
    .clk(clk), .rst(rst), .aluout(aluout), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in), .stall(stall),
    .aluout_out_EXE_MEM(aluout_out_EXE_MEM), .waddr_out_EXE_MEM(waddr_out_EXE_MEM),
    .wdata_WB(wdata_WB), .waddr_WB(waddr_WB), .wen_WB(wen_WB),
    .fwd_en_MEM(fwd_en_MEM), .fwd_waddr_MEM(fwd_waddr_MEM), .fwd_data_MEM(fwd_data_MEM),
    .fwd_en_WB(fwd_en_WB), .fwd_waddr_WB(fwd_waddr_WB), .fwd_data_WB(fwd_data_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  wa;
    logic        rw;
    logic        mr;
    logic        mw;
  } ins_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic        en;
  } wb_t;

  wb_t         exp_q[$];
  logic [15:0] mdl [256];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam ins_t NOP = '{16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction and pushes its expected WB result, using the bench's memory model.
  task automatic drive(input ins_t in);
    wb_t e;
    logic [7:0] ad;
    aluout      = in.alu;
    rdata2_in   = in.sd;
    waddr_in    = in.wa;
    regwrite_in = in.rw;
    memread_in  = in.mr;
    memwrite_in = in.mw;
    stall       = 1'b0;
    ad   = in.alu[7:0];
    e.a  = in.wa;
    e.en = in.rw && (in.wa != 4'd0);
    e.d  = in.mr ? mdl[ad] : in.alu;
    if (in.mw) mdl[ad] = in.sd;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    ins_t prog[$];
    wb_t  e;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      aluout      = 16'($urandom);
      rdata2_in   = 16'($urandom);
      waddr_in    = 4'($urandom);
      regwrite_in = 1'($urandom);
      memread_in  = 1'($urandom);
      memwrite_in = 1'($urandom);
      stall       = 1'($urandom);
      tick();
      n_cmp++;
      if ({aluout_out_EXE_MEM, waddr_out_EXE_MEM, wdata_WB, waddr_WB, wen_WB, fwd_en_MEM,
           fwd_waddr_MEM, fwd_data_MEM, fwd_en_WB, fwd_waddr_WB, fwd_data_WB} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: wdata_WB=%h waddr_WB=%h wen_WB=%b alu_EM=%h required all 0",
                 i, wdata_WB, waddr_WB, wen_WB, aluout_out_EXE_MEM);
      end
    end
    drive(NOP);
    #2 rst = 1'b1;
    exp_q.delete();
    prog.push_back(ins_t'{16'hA5A5, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0});
    prog.push_back(NOP);
    prog.push_back(NOP);
    foreach (prog[i]) begin
      drive(prog[i]);
      tick();
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
          n_bad++;
          $display("FAIL reset_first_instr: got wen=%b waddr=%h wdata=%h, required wen=%b waddr=%h wdata=%h",
                   wen_WB, waddr_WB, wdata_WB, e.en, e.a, e.d);
        end
      end else begin
        n_cmp++;
        if (wen_WB !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_first_edge: wen_WB=%b required 0", wen_WB);
        end
      end
    end
  endtask

  task automatic test_alu_wb();
    ins_t prog[$];
    wb_t  e;
    prog.push_back(ins_t'{16'h1234, 16'h0, 4'd3,  1'b1, 1'b0, 1'b0});
    prog.push_back(ins_t'{16'hCAFE, 16'h0, 4'd15, 1'b1, 1'b0, 1'b0});
    prog.push_back(ins_t'{16'h00FF, 16'h0, 4'd0,  1'b1, 1'b0, 1'b0});
    prog.push_back(ins_t'{16'h7777, 16'h0, 4'd8,  1'b0, 1'b0, 1'b0});
    prog.push_back(ins_t'{16'h0001, 16'h0, 4'd1,  1'b1, 1'b0, 1'b0});
    prog.push_back(NOP);
    foreach (prog[i]) begin
      drive(prog[i]);
      tick();
      n_cmp++;
      if ({aluout_out_EXE_MEM, waddr_out_EXE_MEM} !== {prog[i].alu, prog[i].wa}) begin
        n_bad++;
        $display("FAIL alu_exe_mem[%0d]: got alu=%h waddr=%h, required alu=%h waddr=%h",
                 i, aluout_out_EXE_MEM, waddr_out_EXE_MEM, prog[i].alu, prog[i].wa);
      end
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
          n_bad++;
          $display("FAIL alu_wb[%0d]: got wen=%b waddr=%h wdata=%h, required wen=%b waddr=%h wdata=%h",
                   i, wen_WB, waddr_WB, wdata_WB, e.en, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_store_load();
    ins_t prog[$];
    wb_t  e;
    prog.push_back(ins_t'{16'h0105, 16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b1});
    prog.push_back(ins_t'{16'h0005, 16'h0,    4'd7, 1'b1, 1'b1, 1'b0});
    prog.push_back(ins_t'{16'h0030, 16'h5A5A, 4'd0, 1'b0, 1'b0, 1'b1});
    prog.push_back(ins_t'{16'hFF30, 16'h0,    4'd2, 1'b1, 1'b1, 1'b0});
    prog.push_back(NOP);
    prog.push_back(NOP);
    foreach (prog[i]) begin
      drive(prog[i]);
      tick();
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
          n_bad++;
          $display("FAIL store_load[%0d]: got wen=%b waddr=%h wdata=%h, required wen=%b waddr=%h wdata=%h",
                   i, wen_WB, waddr_WB, wdata_WB, e.en, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    wb_t         e;
    logic [20:0] fexp;
    drive(ins_t'{16'h0042, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0});
    tick();
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
        n_bad++;
        $display("FAIL fwd_prev_wb: got wen=%b waddr=%h wdata=%h, required wen=%b", wen_WB, waddr_WB, wdata_WB, e.en);
      end
    end
`ifdef EXE_MEM_FWD_EN
    fexp = {1'b1, 4'd5, 16'h0042};
`else
    fexp = '0;
`endif
    n_cmp++;
    if ({fwd_en_MEM, fwd_waddr_MEM, fwd_data_MEM} !== fexp) begin
      n_bad++;
      $display("FAIL fwd_mem: got %h required %h", {fwd_en_MEM, fwd_waddr_MEM, fwd_data_MEM}, fexp);
    end
    drive(ins_t'{16'h0009, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) begin
      n_bad++;
      $display("FAIL fwd_instr_wb: got wen=%b waddr=%h wdata=%h, required 1 %h %h", wen_WB, waddr_WB, wdata_WB, e.a, e.d);
    end
    n_cmp++;
    if ({fwd_en_WB, fwd_waddr_WB, fwd_data_WB} !== fexp) begin
      n_bad++;
      $display("FAIL fwd_wb: got %h required %h", {fwd_en_WB, fwd_waddr_WB, fwd_data_WB}, fexp);
    end
    n_cmp++;
    if (fwd_en_MEM !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_mem_load: fwd_en_MEM=%b required 0", fwd_en_MEM);
    end
    drive(NOP);
    tick();
    void'(exp_q.pop_front());
  endtask

  task automatic test_stall();
    wb_t e;
    drive(ins_t'{16'h0305, 16'h1111, 4'd9, 1'b1, 1'b1, 1'b1});
    tick();
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
        n_bad++;
        $display("FAIL stall_prev_wb: got wen=%b required %b", wen_WB, e.en);
      end
    end
    for (int i = 0; i < 2; i++) begin
      aluout      = 16'($urandom);
      rdata2_in   = 16'($urandom);
      waddr_in    = 4'($urandom_range(1, 15));
      regwrite_in = 1'b1;
      memread_in  = 1'b0;
      memwrite_in = 1'b1;
      stall       = 1'b1;
      tick();
      n_cmp++;
      if (wen_WB !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_bubble[%0d]: wen_WB=%b required 0", i, wen_WB);
      end
      n_cmp++;
      if (dut.mem[5] !== 16'hBEEF) begin
        n_bad++;
        $display("FAIL stall_mem_hold[%0d]: mem[5]=%h required beef", i, dut.mem[5]);
      end
      n_cmp++;
      if ({aluout_out_EXE_MEM, waddr_out_EXE_MEM} !== {16'h0305, 4'd9}) begin
        n_bad++;
        $display("FAIL stall_exe_hold[%0d]: alu=%h waddr=%h required 0305 9", i, aluout_out_EXE_MEM, waddr_out_EXE_MEM);
      end
    end
    drive(ins_t'{16'h0005, 16'h0, 4'd4, 1'b1, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) begin
      n_bad++;
      $display("FAIL stall_release_wb: got wen=%b waddr=%h wdata=%h, required 1 %h %h", wen_WB, waddr_WB, wdata_WB, e.a, e.d);
    end
    n_cmp++;
    if (dut.mem[5] !== 16'h1111) begin
      n_bad++;
      $display("FAIL stall_commit: mem[5]=%h required 1111", dut.mem[5]);
    end
    drive(NOP);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) begin
      n_bad++;
      $display("FAIL stall_load_after: got wen=%b waddr=%h wdata=%h, required 1 %h %h", wen_WB, waddr_WB, wdata_WB, e.a, e.d);
    end
  endtask

  task automatic test_reset_mid();
    ins_t prog[$];
    wb_t  e;
    drive(ins_t'{16'h0020, 16'h1000, 4'd0, 1'b0, 1'b0, 1'b1});
    tick();
    drive(NOP);
    tick();
    drive(ins_t'{16'h0020, 16'h7777, 4'd3, 1'b1, 1'b0, 1'b1});
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({aluout_out_EXE_MEM, waddr_out_EXE_MEM, wdata_WB, waddr_WB, wen_WB} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: alu=%h waddr=%h wdata=%h waddr_WB=%h wen=%b required all 0",
               aluout_out_EXE_MEM, waddr_out_EXE_MEM, wdata_WB, waddr_WB, wen_WB);
    end
    drive(NOP);
    tick();
    #2 rst = 1'b1;
    exp_q.delete();
    mdl[8'h20] = 16'h1000;
    prog.push_back(ins_t'{16'h0020, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0});
    prog.push_back(NOP);
    prog.push_back(NOP);
    foreach (prog[i]) begin
      drive(prog[i]);
      tick();
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.en ? ({wen_WB, waddr_WB, wdata_WB} !== {1'b1, e.a, e.d}) : (wen_WB !== 1'b0)) begin
          n_bad++;
          $display("FAIL reset_mid_load[%0d]: got wen=%b waddr=%h wdata=%h, required wen=%b waddr=%h wdata=%h",
                   i, wen_WB, waddr_WB, wdata_WB, e.en, e.a, e.d);
        end
      end
    end
  endtask

  initial begin
    aluout = '0; rdata2_in = '0; waddr_in = '0;
    regwrite_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0; stall = 1'b0;
    test_reset();
    test_alu_wb();
    test_store_load();
    test_forwarding();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
